// File: rtl/gif_loader_pkg.sv
// Shared constants for the GIF frame loader: loader state encoding and
// pixel RAM geometry.
package gif_loader_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;

   localparam logic [2:0] S_HDR_LO = 3'd0;
   localparam logic [2:0] S_HDR_HI = 3'd1;
   localparam logic [2:0] S_PIX_HI = 3'd2;
   localparam logic [2:0] S_PIX_LO = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;

endpackage

// File: rtl/ms_delay_timer.sv
// Millisecond elapsed-time counter: a down-counting prescaler that bumps a
// saturating 16-bit ms count on each terminal count. start clears both.
module ms_delay_timer #(
   parameter int CLKS_PER_MS = 12000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [15:0] ms_elapsed
);

   localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRE_LOAD = PW'(CLKS_PER_MS - 1);

   logic [PW-1:0] pre_cnt;

   always_ff @(posedge clk) begin
      if (reset || start) begin
         pre_cnt    <= PRE_LOAD;
         ms_elapsed <= '0;
      end else if (pre_cnt == '0) begin
         pre_cnt <= PRE_LOAD;
         if (ms_elapsed != 16'hFFFF)
            ms_elapsed <= ms_elapsed + 16'd1;
      end else begin
         pre_cnt <= pre_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/gif_frame_loader.sv
// Packs a delay-tagged byte stream into 16-bit pixel words for the panel RAM,
// then holds the stream until the frame's display delay has run out.
//
// state    | meaning
// S_HDR_LO | expect delay low byte
// S_HDR_HI | expect delay high byte; its acceptance restarts the ms timer
// S_PIX_HI | expect pixel high byte
// S_PIX_LO | expect pixel low byte; RAM write issued on the next cycle
// S_WAIT   | frame complete, stream held until ms_elapsed >= delay
module gif_frame_loader
   import gif_loader_pkg::*;
#(
   parameter int CLKS_PER_MS = 12000,
   parameter int FRAME_WORDS = 4096
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_byte,
   input  logic              i_byte_valid,
   output logic              o_byte_ready,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_data,
   output logic              o_ram_write_stb,
   output logic              o_frame_done
);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [15:0]       delay;
   logic [7:0]        hi_byte;
   logic [ADDR_W-1:0] word_cnt;
   logic [15:0]       ms_elapsed;
   logic              accept;
   logic              timer_start;
   logic              delay_met;

   assign accept      = o_byte_ready && i_byte_valid;
   assign timer_start = accept && (state == S_HDR_HI);
   assign delay_met   = (ms_elapsed >= delay);

   ms_delay_timer #(
      .CLKS_PER_MS(CLKS_PER_MS)
   ) u_timer (
      .clk       (i_clk),
      .reset     (i_reset),
      .start     (timer_start),
      .ms_elapsed(ms_elapsed)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_HDR_LO: if (accept) state_nxt = S_HDR_HI;
         S_HDR_HI: if (accept) state_nxt = S_PIX_HI;
         S_PIX_HI: if (accept) state_nxt = S_PIX_LO;
         S_PIX_LO: if (accept) state_nxt = (word_cnt == LAST_WORD) ? S_WAIT : S_PIX_HI;
         S_WAIT:   if (delay_met) state_nxt = S_HDR_LO;
         default:  state_nxt = S_HDR_LO;
      endcase
   end

   // Ready is registered from the next state so it is low out of reset and
   // drops exactly for the S_WAIT cycles.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state           <= S_HDR_LO;
         o_byte_ready    <= 1'b0;
         o_ram_addr      <= '0;
         o_ram_data      <= '0;
         o_ram_write_stb <= 1'b0;
         o_frame_done    <= 1'b0;
         word_cnt        <= '0;
         delay           <= '0;
         hi_byte         <= '0;
      end else begin
         state           <= state_nxt;
         o_byte_ready    <= (state_nxt != S_WAIT);
         o_ram_write_stb <= 1'b0;
         o_frame_done    <= 1'b0;
         case (state)
            S_HDR_LO: if (accept) delay[7:0]  <= i_byte;
            S_HDR_HI: if (accept) delay[15:8] <= i_byte;
            S_PIX_HI: if (accept) hi_byte     <= i_byte;
            S_PIX_LO: begin
               if (accept) begin
                  o_ram_addr      <= word_cnt;
                  o_ram_data      <= {hi_byte, i_byte};
                  o_ram_write_stb <= 1'b1;
                  if (word_cnt != LAST_WORD)
                     word_cnt <= word_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (delay_met) begin
                  o_frame_done <= 1'b1;
                  word_cnt     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gif_frame_loader.sv
// Bench for gif_frame_loader: a small-frame instance driven from a vector
// table with random stalls, plus a full-size instance for delay saturation.
module tb_gif_frame_loader;

   localparam int CPM1 = 4;
   localparam int FW1  = 8;
   localparam int CPM2 = 1;
   localparam int FW2  = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic        rst1, valid1, ready1, stb1, done1;
   logic [7:0]  byte1;
   logic [11:0] addr1;
   logic [15:0] data1;
   logic        rst2, valid2, ready2, stb2, done2;
   logic [7:0]  byte2;
   logic [11:0] addr2;
   logic [15:0] data2;

   gif_frame_loader #(.CLKS_PER_MS(CPM1), .FRAME_WORDS(FW1)) u_dut1 (
      .i_clk(clk), .i_reset(rst1), .i_byte(byte1), .i_byte_valid(valid1),
      .o_byte_ready(ready1), .o_ram_addr(addr1), .o_ram_data(data1),
      .o_ram_write_stb(stb1), .o_frame_done(done1)
   );

   gif_frame_loader #(.CLKS_PER_MS(CPM2), .FRAME_WORDS(FW2)) u_dut2 (
      .i_clk(clk), .i_reset(rst2), .i_byte(byte2), .i_byte_valid(valid2),
      .o_byte_ready(ready2), .o_ram_addr(addr2), .o_ram_data(data2),
      .o_ram_write_stb(stb2), .o_frame_done(done2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- small instance: monitor and model ----------------
   int          wr_cyc[$];
   logic [11:0] wr_addr[$];
   logic [15:0] wr_data[$];
   int          done_q[$];
   bit          rdy_hist[16384];

   always @(negedge clk) begin
      if (cyc < 16384) rdy_hist[cyc] <= ready1;
      if (stb1 === 1'b1) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(addr1);
         wr_data.push_back(data1);
      end
      if (done1 === 1'b1) done_q.push_back(cyc);
   end

   typedef struct {
      logic [15:0] delay;
      int          stall_pct;
      bit          rand_pix;
      int          exp_hdr_to_done;   // -1: derive from the timing model
   } vec_t;

   logic [15:0] pix[FW1];
   int          lo_edge[FW1];

   // Returns the clock-edge index at which the byte is taken.
   task automatic send1(input logic [7:0] b, input int stall_pct, output int acc_edge);
      int guard = 0;
      acc_edge = -1;
      while (acc_edge < 0) begin
         @(negedge clk);
         if (int'($urandom_range(99)) < stall_pct) begin
            valid1 = 1'b0;
         end else begin
            byte1  = b;
            valid1 = 1'b1;
            if (ready1 === 1'b1) acc_edge = cyc + 1;
         end
         guard++;
         if (guard > 5000 && acc_edge < 0) begin
            n_cmp++; n_err++;
            $display("FAIL send1_timeout: ready never seen, expected ready within 5000 cycles");
            acc_edge = cyc + 1;
         end
      end
   endtask

   task automatic clear_mon1();
      wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); done_q.delete();
   endtask

   task automatic run_frame1(input vec_t v);
      int h, e, exit_edge, guard, low_cnt, n;
      clear_mon1();
      for (int i = 0; i < FW1; i++)
         pix[i] = v.rand_pix ? 16'($urandom) : ((i == 0) ? 16'hC000 : 16'(i));
      send1(v.delay[7:0], v.stall_pct, e);
      send1(v.delay[15:8], v.stall_pct, h);
      for (int i = 0; i < FW1; i++) begin
         send1(pix[i][15:8], v.stall_pct, e);
         send1(pix[i][7:0], v.stall_pct, lo_edge[i]);
      end
      @(negedge clk);
      valid1 = 1'b0;
      // frame may restart no earlier than delay ms after frame start,
      // and never before the cycle following the last write
      exit_edge = h + CPM1 * int'(v.delay) + 1;
      if (exit_edge < lo_edge[FW1-1] + 1) exit_edge = lo_edge[FW1-1] + 1;
      guard = 0;
      while (done_q.size() == 0 && guard < 3000) begin
         @(negedge clk); #1;
         guard++;
      end
      repeat (4) begin @(negedge clk); #1; end
      chk("frame_done_seen", done_q.size(), 1);
      chk("write_count", wr_cyc.size(), FW1);
      n = (wr_cyc.size() < FW1) ? wr_cyc.size() : FW1;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("wr_addr[%0d]", i), wr_addr[i], i);
         chk($sformatf("wr_data[%0d]", i), wr_data[i], pix[i]);
         chk($sformatf("wr_cycle[%0d]", i), wr_cyc[i], lo_edge[i]);
      end
      if (done_q.size() > 0) begin
         chk("done_cycle", done_q[0], exit_edge);
         if (v.exp_hdr_to_done >= 0)
            chk("hdr_to_done", done_q[0] - h, v.exp_hdr_to_done);
      end
      low_cnt = 0;
      for (int c = h; c <= exit_edge && c < 16384; c++)
         if (!rdy_hist[c]) low_cnt++;
      chk("ready_low_cycles", low_cnt, exit_edge - lo_edge[FW1-1]);
   endtask

   task automatic seq1();
      vec_t vecs[7];
      int e;
      vecs[0] = '{16'h0002, 0,  1'b0, 17};
      vecs[1] = '{16'h0002, 50, 1'b0, -1};
      vecs[2] = '{16'h0000, 80, 1'b0, -1};
      vecs[3] = '{16'h0001, 80, 1'b1, -1};
      vecs[4] = '{16'h0100, 0,  1'b0, 1025};
      vecs[5] = '{16'h0008, 0,  1'b1, 33};
      vecs[6] = '{16'h0003, 30, 1'b1, -1};

      valid1 = 1'b0; byte1 = 8'h00; rst1 = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", ready1, 0);
      chk("rst_addr", addr1, 0);
      chk("rst_data", data1, 0);
      chk("rst_stb", stb1, 0);
      chk("rst_done", done1, 0);
      rst1 = 1'b0;

      for (int i = 0; i < 7; i++) run_frame1(vecs[i]);

      // reset after three words, with a fourth high byte already taken
      clear_mon1();
      send1(8'h05, 0, e);
      send1(8'h00, 0, e);
      for (int i = 0; i < 3; i++) begin
         send1(8'hA0 + 8'(i), 0, e);
         send1(8'h10 + 8'(i), 0, e);
      end
      send1(8'hEE, 0, e);
      @(negedge clk);
      valid1 = 1'b0;
      rst1   = 1'b1;
      @(negedge clk); #1;
      chk("midrst_ready", ready1, 0);
      chk("midrst_addr", addr1, 0);
      chk("midrst_data", data1, 0);
      chk("midrst_stb", stb1, 0);
      chk("midrst_done", done1, 0);
      chk("midrst_writes_before", wr_cyc.size(), 3);
      rst1 = 1'b0;
      run_frame1('{16'h0006, 0, 1'b1, 25});
   endtask

   // ---------------- full-size instance: saturation ----------------
   int k2 = 0;
   int done2_n = 0;
   int done2_cyc = -1;

   function automatic logic [15:0] pix2(input int k);
      return 16'(k * 40503 + 7);
   endfunction

   always @(negedge clk) begin
      if (stb2 === 1'b1) begin
         chk("dut2_addr", addr2, 32'(k2 % FW2));
         chk("dut2_data", data2, pix2(k2));
         k2++;
      end
      if (done2 === 1'b1) begin
         done2_n++;
         done2_cyc = cyc;
      end
   end

   task automatic send2(input logic [7:0] b, output int acc_edge);
      int guard = 0;
      acc_edge = -1;
      while (acc_edge < 0) begin
         @(negedge clk);
         byte2  = b;
         valid2 = 1'b1;
         if (ready2 === 1'b1) acc_edge = cyc + 1;
         guard++;
         if (guard > 5000 && acc_edge < 0) begin
            n_cmp++; n_err++;
            $display("FAIL send2_timeout: ready never seen, expected ready within 5000 cycles");
            acc_edge = cyc + 1;
         end
      end
   endtask

   task automatic frame2(input logic [15:0] d, input int base, input int exp_done_n);
      int h, e, last_lo, exit_edge, guard;
      send2(d[7:0], e);
      send2(d[15:8], h);
      for (int i = 0; i < FW2; i++) begin
         send2(pix2(base + i) >> 8, e);
         send2(pix2(base + i), last_lo);
      end
      @(negedge clk);
      valid2 = 1'b0;
      exit_edge = h + CPM2 * int'(d) + 1;
      if (exit_edge < last_lo + 1) exit_edge = last_lo + 1;
      guard = 0;
      while (done2_n < exp_done_n && guard < 70000) begin
         @(negedge clk); #1;
         guard++;
      end
      chk("dut2_done_count", done2_n, exp_done_n);
      chk("dut2_done_cycle", done2_cyc, exit_edge);
   endtask

   task automatic seq2();
      valid2 = 1'b0; byte2 = 8'h00; rst2 = 1'b1;
      repeat (3) @(negedge clk);
      rst2 = 1'b0;
      frame2(16'hFFFF, 0, 1);
      repeat (100) @(negedge clk);
      #1;
      chk("dut2_ms_saturated", u_dut2.u_timer.ms_elapsed, 16'hFFFF);
      chk("dut2_done_once", done2_n, 1);
      frame2(16'h0001, FW2, 2);
      repeat (4) @(negedge clk);
      #1;
      chk("dut2_total_writes", k2, 2 * FW2);
      chk("dut2_done_total", done2_n, 2);
   endtask

   initial begin
      rst1 = 1'b1; rst2 = 1'b1;
      valid1 = 1'b0; valid2 = 1'b0;
      byte1 = 8'h00; byte2 = 8'h00;
      fork
         seq1();
         seq2();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #950000;
      n_cmp++; n_err++;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected completion before 95000", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
